// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing for the GPR write scoreboard and its one-hot helper.
package reg_scoreboard_pkg;

  localparam int REG_ID_W  = 3;
  localparam int NUM_REGS  = 1 << REG_ID_W;
  localparam int CNT_W     = 2;
  localparam int CNT_MAX_I = (1 << CNT_W) - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_MAX_I);

  typedef logic [REG_ID_W-1:0] reg_id_t;
  typedef logic [CNT_W-1:0]    cnt_t;
  typedef logic [NUM_REGS-1:0] reg_vec_t;

  function automatic reg_vec_t onehot(input reg_id_t id);
    reg_vec_t v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback side of the scoreboard. The decode side (master) drives
// sources, issue, writeback and flush; the scoreboard (slave) answers with
// issue_ready / dep_stall, both combinational within the same cycle.
// Handshake: an issue with issue_we fires on an edge where issue_v & issue_ready.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic     flush;
  logic     src1_v;
  reg_id_t  src1_id;
  logic     src2_v;
  reg_id_t  src2_id;
  logic     issue_v;
  logic     issue_we;
  reg_id_t  issue_dst;
  logic     wb_v;
  reg_id_t  wb_dst;
  logic     issue_ready;
  logic     dep_stall;
  reg_vec_t busy;
  logic     underflow_err;

  modport master (
    output flush, src1_v, src1_id, src2_v, src2_id,
           issue_v, issue_we, issue_dst, wb_v, wb_dst,
    input  issue_ready, dep_stall, busy, underflow_err
  );

  modport slave (
    input  flush, src1_v, src1_id, src2_v, src2_id,
           issue_v, issue_we, issue_dst, wb_v, wb_dst,
    output issue_ready, dep_stall, busy, underflow_err
  );
endinterface

// File: rtl/reg_scoreboard_sb_cnt_slice.sv
// One register's pending-write counter: saturating up/down, holds at zero.
// uflow flags a lone decrement at zero so the top can latch the error.
module sb_cnt_slice
  import reg_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  output cnt_t cnt,
  output logic busy,
  output logic uflow
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy  = (cnt != '0);
  // A flush in the same cycle masks the error.
  assign uflow = dec & ~inc & ~clr & (cnt == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Writer-side register scoreboard: counts in-flight GPR writes and stalls
// decode when a valid source has a pending write or the destination is full.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  reg_scoreboard_if.slave  sb
);

  cnt_t     cnt [NUM_REGS];
  reg_vec_t busy_vec;
  reg_vec_t uflow_vec;
  reg_vec_t inc_vec;
  reg_vec_t dec_vec;
  logic     dep_stall;
  logic     full_dst;
  logic     issue_ready;
  logic     issue_fire;
  logic     underflow_q;

  // No writeback bypass: stall comes straight from the registered counters.
  assign dep_stall   = (sb.src1_v & busy_vec[sb.src1_id]) |
                       (sb.src2_v & busy_vec[sb.src2_id]);
  assign full_dst    = sb.issue_we & (cnt[sb.issue_dst] == CNT_MAX);
  assign issue_ready = ~dep_stall & ~full_dst;
  assign issue_fire  = sb.issue_v & issue_ready & sb.issue_we;

  assign inc_vec = onehot(sb.issue_dst) & {NUM_REGS{issue_fire}};
  assign dec_vec = onehot(sb.wb_dst)    & {NUM_REGS{sb.wb_v}};

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slice
    sb_cnt_slice u_slice (
      .clk   (clk),
      .reset (reset),
      .clr   (sb.flush),
      .inc   (inc_vec[i]),
      .dec   (dec_vec[i]),
      .cnt   (cnt[i]),
      .busy  (busy_vec[i]),
      .uflow (uflow_vec[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow_q <= 1'b0;
    end else if (|uflow_vec) begin
      underflow_q <= 1'b1;
    end
  end

  assign sb.dep_stall     = dep_stall;
  assign sb.issue_ready   = issue_ready;
  assign sb.busy          = busy_vec;
  assign sb.underflow_err = underflow_q;

endmodule
